// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// state encodings, handshake constants and small operation-decode helpers.
package mdu_iter_pkg;

  // Even codes are signed, odd codes are the unsigned twins.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5,
    MDU_MSUB  = 3'd6,
    MDU_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } mdu_state_e;

  localparam logic MduStart    = 1'b1;
  localparam logic MduStop     = 1'b0;
  localparam logic MduReady    = 1'b1;
  localparam logic MduNotReady = 1'b0;
  // Reset level of the rst input (active-high).
  localparam logic RstEnable   = 1'b1;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB});
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op inside {MDU_DIV, MDU_DIVU});
  endfunction

  function automatic logic op_is_madd(input mdu_op_e op);
    return (op inside {MDU_MADD, MDU_MADDU});
  endfunction

  function automatic logic op_is_msub(input mdu_op_e op);
    return (op inside {MDU_MSUB, MDU_MSUBU});
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational radix-2 step of the shared datapath.
// Divide mode: acc = {remainder, quotient}; restoring shift-subtract.
// Multiply mode: acc = {hi, lo}, lo holds the remaining multiplier bits;
// conditional add of the multiplicand into hi, then shift right.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode,
  input  logic [WIDTH-1:0]     operand,
  input  logic [2*WIDTH-1:0]   acc_in,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] part;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] sum;

  // Compute both step flavours and select by mode.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here the
    // defaults come first) so that no latch is inferred.
    acc_out = acc_in;
    // Partial remainder shifted left with the next dividend bit; it is always
    // below twice the divisor, so one extra bit makes diff[WIDTH] a borrow.
    part = acc_in[2*WIDTH-1:WIDTH-1];
    diff = part - {1'b0, operand};
    sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    if (div_mode) begin
      if (!diff[WIDTH]) acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      else              acc_out = {part[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage. Operands are reduced to
// magnitudes on acceptance, STEPS_PER_CYCLE radix-2 steps run per clock, and
// the sign fix plus HI/LO accumulation happen on the final clock.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int N     = WIDTH / STEPS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(N - 1);

  mdu_state_e state_q, state_d;
  mdu_op_e    op_q, op_in;

  logic                 neg_res_q, neg_rem_q;
  logic [2*WIDTH-1:0]   hilo_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 accept, last_step, in_signed, in_div, div_mode;
  logic                 sign1, sign2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [2*WIDTH-1:0]   prod, final_res;
  logic [WIDTH-1:0]     quo, rem;

  logic [2*WIDTH-1:0]   chain [0:STEPS_PER_CYCLE];

  assign op_in     = mdu_op_e'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign div_mode  = op_is_div(op_q);
  assign accept    = (state_q == S_IDLE) && !annul_i && (start_i == MduStart);
  assign last_step = (cnt_q == CntLast);
  assign busy_o    = (state_q != S_IDLE);

  // Operand signs and magnitudes as seen in the accepting cycle.
  always_comb begin
    sign1 = in_signed && opdata1_i[WIDTH-1];
    sign2 = in_signed && opdata2_i[WIDTH-1];
    mag1  = sign1 ? (WIDTH'(0) - opdata1_i) : opdata1_i;
    mag2  = sign2 ? (WIDTH'(0) - opdata2_i) : opdata2_i;
  end

  // Chain of radix-2 steps evaluated within one clock.
  assign chain[0] = acc_q;
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    mdu_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (div_mode),
      .operand  (opnd_q),
      .acc_in   (chain[g]),
      .acc_out  (chain[g+1])
    );
  end

  // Sign fix and accumulation applied to the final step output.
  always_comb begin
    prod = neg_res_q ? ((2*WIDTH)'(0) - chain[STEPS_PER_CYCLE]) : chain[STEPS_PER_CYCLE];
    quo  = chain[STEPS_PER_CYCLE][WIDTH-1:0];
    rem  = chain[STEPS_PER_CYCLE][2*WIDTH-1:WIDTH];
    if (neg_res_q) quo = WIDTH'(0) - quo;
    if (neg_rem_q) rem = WIDTH'(0) - rem;
    final_res = prod;
    if (op_is_div(op_q))       final_res = {rem, quo};
    else if (op_is_madd(op_q)) final_res = hilo_q + prod;
    else if (op_is_msub(op_q)) final_res = hilo_q - prod;
  end

  // Next-state logic; annul always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = (in_div && (opdata2_i == '0)) ? S_BYZERO : S_ON;
      S_BYZERO: state_d = annul_i ? S_IDLE : S_END;
      S_ON:     state_d = annul_i ? S_IDLE : (last_step ? S_END : S_ON);
      S_END:    state_d = (annul_i || (start_i == MduStop)) ? S_IDLE : S_END;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  // Operand latch, iteration registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst == RstEnable) begin
      op_q      <= MDU_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hilo_q    <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      result_o  <= '0;
      ready_o   <= MduNotReady;
    end else begin
      if (accept) begin
        op_q      <= op_in;
        neg_res_q <= sign1 ^ sign2;
        neg_rem_q <= sign1;
        hilo_q    <= hilo_i;
        cnt_q     <= '0;
        // Divide iterates on the dividend with the divisor as operand;
        // multiply iterates on the multiplier with the multiplicand as operand.
        acc_q     <= in_div ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
        opnd_q    <= in_div ? mag2 : mag1;
      end else if (state_q == S_ON) begin
        acc_q <= chain[STEPS_PER_CYCLE];
        cnt_q <= cnt_q + CNT_W'(1);
      end
      ready_o <= (state_d == S_END) ? MduReady : MduNotReady;
      // Result is zero whenever not ready; captured once on entry from ON.
      if (state_d != S_END)    result_o <= '0;
      else if (state_q == S_ON) result_o <= final_res;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: one instance with one step per clock and
// one with four, driven in lockstep. Expected results are queued when an
// operation is launched and popped when each instance raises ready_o.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [63:0] hilo  = '0;

  logic [63:0] result1, result4;
  logic        ready1, ready4, busy1, busy4;

  int checks = 0;
  int errors = 0;
  logic [63:0] q1[$];
  logic [63:0] q4[$];

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u_k1 (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .hilo_i(hilo),
    .result_o(result1), .ready_o(ready1), .busy_o(busy1)
  );

  mdu_iter #(.WIDTH(32), .STEPS_PER_CYCLE(4)) u_k4 (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .hilo_i(hilo),
    .result_o(result4), .ready_o(ready4), .busy_o(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model written with plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] h);
    longint      sx, sy, q, r;
    logic [63:0] ps, pu, qv, rv;
    logic [31:0] qu, ru;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ps = 64'(sx * sy);
    pu = {32'd0, x} * {32'd0, y};
    case (mdu_op_e'(o))
      MDU_MULT:  return ps;
      MDU_MULTU: return pu;
      MDU_MADD:  return h + ps;
      MDU_MADDU: return h + pu;
      MDU_MSUB:  return h - ps;
      MDU_MSUBU: return h - pu;
      MDU_DIV: begin
        if (y == 32'd0) return 64'd0;
        q  = sx / sy;
        r  = sx % sy;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (y == 32'd0) return 64'd0;
        qu = x / y;
        ru = x % y;
        return {ru, qu};
      end
    endcase
  endfunction

  // Launch one op, hold start until both instances are ready, optionally
  // stay in END for 'hold' cycles, then drop start and expect IDLE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] h, input logic [63:0] exp, input int hold);
    bit          seen1 = 1'b0;
    bit          seen4 = 1'b0;
    bit          bz;
    int          lat1, lat4;
    logic [63:0] e;
    bz   = ((o == MDU_DIV) || (o == MDU_DIVU)) && (y == 32'd0);
    lat1 = bz ? 2 : 33;
    lat4 = bz ? 2 : 9;
    q1.push_back(exp);
    q4.push_back(exp);
    op = o; a = x; b = y; hilo = h; start = 1'b1;
    for (int cyc = 1; cyc <= 100 && !(seen1 && seen4); cyc++) begin
      @(posedge clk); #1;
      if (ready1 && !seen1) begin
        seen1 = 1'b1;
        check("latency_k1", 64'(cyc), 64'(lat1));
        e = q1.pop_front();
        check("result_k1", result1, e);
      end
      if (ready4 && !seen4) begin
        seen4 = 1'b1;
        check("latency_k4", 64'(cyc), 64'(lat4));
        e = q4.pop_front();
        check("result_k4", result4, e);
      end
    end
    if (!seen1) begin check("timeout_k1", 64'(seen1), 64'd1); q1.delete(); end
    if (!seen4) begin check("timeout_k4", 64'(seen4), 64'd1); q4.delete(); end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", {62'd0, ready1, ready4}, 64'd3);
      check("hold_result_k1", result1, exp);
      check("hold_result_k4", result4, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_ready_busy", {60'd0, ready1, ready4, busy1, busy4}, 64'd0);
    check("drop_result", result1 | result4, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    logic [63:0] rh;
    bit          saw;

    #2;
    check("reset_outputs", {60'd0, ready1, ready4, busy1, busy4}, 64'd0);
    check("reset_result", result1 | result4, 64'd0);
    #6 rst = 1'b0;
    @(posedge clk); #1;

    // Directed operations.
    run_op(MDU_DIVU,  32'd100,        32'd7,          64'd0, 64'h00000002_0000000E, 2);
    run_op(MDU_DIV,   32'hFFFFFFF9,   32'd2,          64'd0, 64'hFFFFFFFF_FFFFFFFD, 0);
    run_op(MDU_DIV,   32'd5,          32'd0,          64'd0, 64'd0, 1);
    run_op(MDU_MULT,  32'hFFFFFFFD,   32'd5,          64'd0, 64'hFFFFFFFF_FFFFFFF1, 0);
    run_op(MDU_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'd0, 64'hFFFFFFFE_00000001, 0);
    run_op(MDU_MADD,  32'd3,          32'd4,          64'd10, 64'd22, 0);
    run_op(MDU_MSUB,  32'd3,          32'd4,          64'd10, 64'hFFFFFFFF_FFFFFFFE, 0);
    run_op(MDU_MADDU, 32'd1,          32'd1,          64'hFFFFFFFF_FFFFFFFF, 64'd0, 0);
    run_op(MDU_DIV,   32'h80000000,   32'hFFFFFFFF,   64'd0, 64'h00000000_80000000, 0);

    // Annul in cycle 10 of a divide.
    op = MDU_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("annul_busy_before", {62'd0, busy1, ready1}, 64'd2);
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_idle", {60'd0, busy1, busy4, ready1, ready4}, 64'd0);
    check("annul_result", result1 | result4, 64'd0);
    saw = 1'b0;
    repeat (40) begin @(posedge clk); #1; saw = saw | ready1 | ready4 | busy1; end
    check("annul_never_ready", 64'(saw), 64'd0);

    // start together with annul in IDLE is not accepted.
    op = MDU_MULT; a = 32'd2; b = 32'd3; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    check("start_annul_rejected", {62'd0, busy1, busy4}, 64'd0);
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-operation.
    op = MDU_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("busy_mid_on", {62'd0, busy1, busy4}, 64'd3);
    #2 rst = 1'b1;
    #1;
    check("async_reset_flags", {60'd0, busy1, busy4, ready1, ready4}, 64'd0);
    check("async_reset_result", result1 | result4, 64'd0);
    start = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("after_reset_idle", {62'd0, busy1, busy4}, 64'd0);

    // Randomised operations against the reference model.
    for (int n = 0; n < 1000; n++) begin
      ro = 3'($urandom_range(0, 7));
      rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      if ($urandom_range(0, 15) == 0)     ry = 32'd0;
      else if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 15)) ^ {32{rx[0]}};
      else                                ry = 32'($urandom);
      rh = {32'($urandom), 32'($urandom)};
      run_op(ro, rx, ry, rh, model(ro, rx, ry, rh), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
